gslcd_pixel_unpack: RTL and testbench

- Sits between the LCD controller's AXI read master (R channel) and its LCD timing/output stage.
- Converts the packed framebuffer word stream into 24-bit pixels: 32-bit little-endian words, 3 bytes per pixel, so 3 words carry 4 pixels.
- Tags each pixel with start-of-frame and end-of-line markers.
- Sustains 1 pixel/cycle under no backpressure.

---
 rtl/gslcd_pkg.sv | 32 +++
 rtl/gslcd_pixel_unpack_if.sv | 32 +++
 rtl/gslcd_pixel_unpack.sv | 123 ++++++++++++
 tb/tb_gslcd_pixel_unpack.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gslcd_pkg.sv
// ============================================================================
// gslcd_pkg
// Shared LCD geometry and framebuffer packing constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gslcd_pkg;

    localparam int LCD_H_ACTIVE    = 800;
    localparam int LCD_V_ACTIVE    = 480;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int AXI_DATA_BYTES  = 4;
    localparam int BURST_BYTES     = 64;

    localparam int WORD_W   = AXI_DATA_BYTES * 8;
    localparam int PIXEL_W  = BYTES_PER_PIXEL * 8;
    localparam int BUF_BYTES = 2 * BYTES_PER_PIXEL;
    localparam int BUF_W    = BUF_BYTES * 8;
    localparam int CNT_W    = 3;

    function automatic int frame_bytes(input int h, input int v);
        return h * v * BYTES_PER_PIXEL;
    endfunction

    // The DMA issues whole 16-beat bursts, so a frame must be a burst multiple.
    localparam int FRAME_BYTES = frame_bytes(LCD_H_ACTIVE, LCD_V_ACTIVE);
    localparam bit FRAME_BURST_ALIGNED = (FRAME_BYTES % BURST_BYTES) == 0;

endpackage

`default_nettype wire

// File: rtl/gslcd_pixel_unpack_if.sv
// ============================================================================
// gslcd_pixel_unpack_if
// Word-in / pixel-out stream bundle for the pixel unpacker.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gslcd_pixel_unpack_if;
    import gslcd_pkg::*;

    logic [WORD_W-1:0]  s_data;
    logic               s_valid;
    logic               s_ready;
    logic [PIXEL_W-1:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_user;
    logic               m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_user, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_user, m_last
    );

endinterface

`default_nettype wire

// File: rtl/gslcd_pixel_unpack.sv
// ============================================================================
// gslcd_pixel_unpack
// Unpacks 32-bit framebuffer words into tagged 24-bit pixels, 1 pixel/cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gslcd_pixel_unpack
    import gslcd_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    parameter int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  wire logic             aclk,
    input  wire logic             areset,
    input  wire logic             frame_start,
    gslcd_pixel_unpack_if.slave   bus,
    output logic                  eof
);

    localparam logic [CNT_W-1:0] CNT_PIXEL = CNT_W'(BYTES_PER_PIXEL);
    localparam logic [CNT_W-1:0] CNT_WORD  = CNT_W'(AXI_DATA_BYTES);
    localparam logic [CNT_W-1:0] CNT_ROOM  = CNT_W'(BUF_BYTES - AXI_DATA_BYTES);
    localparam logic [CNT_W-1:0] CNT_ROOM_FIRE = CNT_W'(BUF_BYTES - 1);
    localparam logic [XW-1:0]    X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]    Y_LAST    = YW'(V_ACTIVE - 1);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic             r_eof;

    logic             w_m_valid;
    logic             w_fire;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_frame_wrap;
    logic [CNT_W-1:0] w_cnt_base;
    logic [BUF_W-1:0] w_buf_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic [BUF_W-1:0] w_buf_next;
    logic [5:0]       w_shamt;
    logic [BUF_W-1:0] w_word_mask;
    logic [BUF_W-1:0] w_word_ext;

    assign w_m_valid    = (r_cnt >= CNT_PIXEL);
    assign w_x_last     = (r_x == X_LAST);
    assign w_y_last     = (r_y == Y_LAST);
    // A pixel presented during frame_start is never consumed.
    assign w_fire       = w_m_valid && bus.m_ready && !frame_start;
    assign w_s_ready    = !frame_start &&
                          ((r_cnt <= CNT_ROOM) || (w_fire && (r_cnt <= CNT_ROOM_FIRE)));
    assign w_accept     = bus.s_valid && w_s_ready;
    assign w_frame_wrap = w_fire && w_x_last && w_y_last;

    // Shift out the fired pixel first, then append the accepted word behind
    // whatever remains. Leftover bytes at a frame wrap are discarded.
    always_comb begin
        w_cnt_base  = r_cnt;
        w_buf_base  = r_buf;
        if (w_fire) begin
            w_cnt_base = r_cnt - CNT_PIXEL;
            w_buf_base = r_buf >> PIXEL_W;
        end
        if (w_frame_wrap) begin
            w_cnt_base = '0;
            w_buf_base = '0;
        end

        w_shamt     = {w_cnt_base, 3'b000};
        w_word_ext  = {{(BUF_W-WORD_W){1'b0}}, bus.s_data};
        w_word_mask = {{(BUF_W-WORD_W){1'b0}}, {WORD_W{1'b1}}} << w_shamt;

        w_buf_next  = w_buf_base;
        w_cnt_next  = w_cnt_base;
        if (w_accept) begin
            w_buf_next = (w_buf_base & ~w_word_mask) | (w_word_ext << w_shamt);
            w_cnt_next = w_cnt_base + CNT_WORD;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_eof <= 1'b0;
        end else if (frame_start) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_eof <= 1'b0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            r_eof <= w_frame_wrap;
            if (w_fire) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = r_buf[PIXEL_W-1:0];
    assign bus.m_user  = (r_x == '0) && (r_y == '0);
    assign bus.m_last  = w_x_last;
    assign eof         = r_eof;

endmodule

`default_nettype wire

// File: tb/tb_gslcd_pixel_unpack.sv
// ============================================================================
// tb_gslcd_pixel_unpack
// Randomized bench for the pixel unpacker against a byte-queue reference.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gslcd_pixel_unpack;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int FRAME = H * V;
    localparam int WPF   = FRAME * 3 / 4;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic eof;

    always #5 clk = ~clk;

    gslcd_pixel_unpack_if bus ();

    gslcd_pixel_unpack #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) u_dut (
        .aclk        (clk),
        .areset      (rst),
        .frame_start (frame_start),
        .bus         (bus.slave),
        .eof         (eof)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: a FIFO of frame bytes and the index of the next pixel in the frame.
    logic [7:0]  q[$];
    int          idx;
    bit          eof_exp;

    int          src_idx;
    bit          pend;
    bit          use_ramp;
    int          valid_pct;
    int          ready_pct;
    int          fired_total;
    int          eof_seen;
    int          sready_low;
    logic [23:0] fired_log[$];
    logic [31:0] dir_words[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ramp_word(input int k);
        logic [31:0] w;
        int j;
        int p;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            j = 4 * k + b;
            p = j / 3;
            w[8*b +: 8] = 8'((p >> (8 * (j % 3))) & 255);
        end
        return w;
    endfunction

    task automatic cycle(input bit fs, input bit rs);
        bit          vld;
        bit          exp_valid;
        bit          fire;
        bit          exp_sready;
        bit          accept;
        logic [23:0] exp_data;
        @(negedge clk);
        rst         = rs;
        frame_start = fs;
        bus.m_ready = ($urandom_range(0, 99) < ready_pct);
        if (use_ramp) begin
            vld        = pend || ($urandom_range(0, 99) < valid_pct);
            bus.s_data = ramp_word(src_idx % WPF);
        end else begin
            vld        = (src_idx < 3);
            bus.s_data = (src_idx < 3) ? dir_words[src_idx] : 32'h0;
        end
        bus.s_valid = vld;
        #1;
        exp_valid  = (q.size() >= 3);
        fire       = exp_valid && bus.m_ready && !fs;
        exp_sready = !fs && ((q.size() <= 2) || (exp_valid && bus.m_ready && q.size() <= 5));
        check("s_ready", 32'(bus.s_ready), 32'(exp_sready));
        check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
        check("eof", 32'(eof), 32'(eof_exp));
        if (eof === 1'b1) eof_seen++;
        if (!bus.s_ready) sready_low++;
        if (exp_valid) begin
            exp_data = {q[2], q[1], q[0]};
            check("m_data", 32'(bus.m_data), 32'(exp_data));
            check("m_user", 32'(bus.m_user), 32'(idx == 0));
            check("m_last", 32'(bus.m_last), 32'((idx % H) == H - 1));
            if (fire && use_ramp) check("ramp", 32'(bus.m_data), 32'(idx));
        end
        accept = vld && exp_sready;
        pend   = vld && !accept;
        if (rs) begin
            q.delete();
            idx = 0; eof_exp = 0; src_idx = 0; pend = 0;
        end else if (fs) begin
            q.delete();
            idx = 0; eof_exp = 0; src_idx = 0;
        end else begin
            eof_exp = 0;
            if (fire) begin
                fired_log.push_back({q[2], q[1], q[0]});
                fired_total++;
                repeat (3) void'(q.pop_front());
                idx++;
                if (idx == FRAME) begin
                    idx = 0;
                    q.delete();
                    eof_exp = 1;
                end
            end
            if (accept) begin
                for (int b = 0; b < 4; b++) q.push_back(bus.s_data[8*b +: 8]);
                src_idx++;
            end
        end
    endtask

    task automatic reset_checks();
        @(negedge clk);
        rst         = 1'b0;
        frame_start = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_m_user", 32'(bus.m_user), 32'd1);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_eof", 32'(eof), 32'd0);
    endtask

    task automatic run_pixels(input int n, input int budget);
        int target;
        target = fired_total + n;
        while (fired_total < target && budget > 0) begin
            cycle(1'b0, 1'b0);
            budget--;
        end
        check("run_timeout", 32'(fired_total >= target), 32'd1);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        idx = 0; eof_exp = 0; src_idx = 0; pend = 0; use_ramp = 0;
        valid_pct = 100; ready_pct = 100; fired_total = 0; eof_seen = 0;
        dir_words[0] = 32'h0100_0000;
        dir_words[1] = 32'h0002_0000;
        dir_words[2] = 32'h0000_0300;
        repeat (3) @(negedge clk);
        reset_checks();

        // Three hand-built words must yield pixels 0..3 back-to-back.
        fired_log.delete();
        sready_low = 0;
        repeat (6) cycle(1'b0, 1'b0);
        check("dir_count", 32'(fired_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < fired_log.size(); i++)
            check("dir_pixel", 32'(fired_log[i]), 32'(i));
        check("dir_sready_low", 32'(sready_low), 32'd1);

        // Two whole ramp frames at full rate.
        cycle(1'b0, 1'b1);
        reset_checks();
        use_ramp = 1;
        eof_seen = 0;
        run_pixels(2 * FRAME, 2 * FRAME + 40);
        repeat (2) cycle(1'b0, 1'b0);
        check("eof_pulses", 32'(eof_seen), 32'd2);

        // Random stalls on both sides.
        valid_pct = 60; ready_pct = 50;
        run_pixels(3 * FRAME, 3000);

        // frame_start after two words: one pixel out, five bytes discarded.
        valid_pct = 100; ready_pct = 100;
        cycle(1'b0, 1'b1);
        reset_checks();
        fired_log.delete();
        repeat (2) cycle(1'b0, 1'b0);
        check("fs_prior_pixels", 32'(fired_log.size()), 32'd1);
        cycle(1'b1, 1'b0);
        run_pixels(FRAME + 5, FRAME + 60);

        // Reset mid-line with a stalled valid pixel.
        ready_pct = 0;
        repeat (4) cycle(1'b0, 1'b0);
        check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        cycle(1'b0, 1'b1);
        reset_checks();
        ready_pct = 100; valid_pct = 70;
        run_pixels(FRAME, 1000);

        // frame_start while a word is offered and a pixel is accepted.
        valid_pct = 100;
        repeat (5) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        valid_pct = 60; ready_pct = 60;
        run_pixels(FRAME + 10, 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
